// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: 2-entry skid buffer with valid/ready and synchronous flush.
// Define PIPE_STAGE_STATS_EN to build the saturating stall/bubble statistics counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_main_valid;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_accept;
    logic              w_drain;

    // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally
    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

    assign w_accept = in_valid & ~r_skid_valid;
    assign w_drain  = r_main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_data  <= in_data;
                        r_main_valid <= 1'b1;
                        r_state      <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        r_main_data <= in_data;
                    end else if (w_drain) begin
                        r_main_valid <= 1'b0;
                        r_state      <= ST_EMPTY;
                    end else if (w_accept) begin
                        r_skid_data  <= in_data;
                        r_skid_valid <= 1'b1;
                        r_state      <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        r_main_data  <= r_skid_data;
                        r_skid_valid <= 1'b0;
                        r_state      <= ST_ONE;
                    end
                end
                default: begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_state      <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Counters saturate instead of wrapping; flush deliberately does not clear them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_main_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!r_main_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, reset/stats sequences, and random traffic
// checked against a queue-based model of a 2-deep in-order stage.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic [1:0]  stall_cnt2;
    logic [1:0]  bubble_cnt2;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data[7:0]), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of up to two payloads; out_data shows the last front entry seen
    logic [31:0] q[$];
    logic [31:0] last_front;
    int unsigned m_stall;
    int unsigned m_bubble;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int unsigned v, input int unsigned max);
        return (v > max) ? 64'(max) : 64'(v);
    endfunction

    task automatic model_reset();
        q.delete();
        last_front = '0;
        m_stall    = 0;
        m_bubble   = 0;
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_data", 64'(out_data), 64'(last_front));
        chk("stall_cnt", 64'(stall_cnt), STATS ? sat(m_stall, 65535) : 64'd0);
        chk("bubble_cnt", 64'(bubble_cnt), STATS ? sat(m_bubble, 65535) : 64'd0);
        chk("out_valid_w8", 64'(out_valid2), 64'(q.size() > 0));
        chk("out_data_w8", 64'(out_data2), 64'(last_front[7:0]));
        chk("stall_cnt_w2", 64'(stall_cnt2), STATS ? sat(m_stall, 3) : 64'd0);
        chk("bubble_cnt_w2", 64'(bubble_cnt2), STATS ? sat(m_bubble, 3) : 64'd0);
    endtask

    // Advance one clock with the inputs currently driven, update the model, compare at edge+1
    task automatic tick();
        bit acc;
        bit drn;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready) m_stall++;
        if (q.size() == 0) m_bubble++;
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(in_data);
        end
        if (q.size() > 0) last_front = q[0];
        check_all();
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_od;
    } vec_t;

    vec_t vt[16];

    initial begin
        // stream 1,2,3 then drain
        vt[0]  = '{1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 1'b1, 32'h1};
        vt[1]  = '{1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 1'b1, 32'h2};
        vt[2]  = '{1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 32'h3};
        vt[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h3};
        // stall: A into main, B into skid, C refused, then drain A and B
        vt[4]  = '{1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 32'hA};
        vt[5]  = '{1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 1'b0, 32'hA};
        vt[6]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 32'hA};
        vt[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB};
        vt[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hB};
        // flush while FULL with a new payload offered
        vt[9]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11};
        vt[10] = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h11};
        vt[11] = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11};
        vt[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h11};
        // flush in ONE while draining and offering
        vt[13] = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h44};
        vt[14] = '{1'b1, 1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 32'h44};
        vt[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h44};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].fl, vt[i].iv, vt[i].d, vt[i].ordy);
            tick();
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_ir));
            chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vt[i].e_od));
        end

        // reset while FULL
        drive(1'b0, 1'b1, 32'hDEAD0001, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'hDEAD0002, 1'b0);
        tick();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();

        // statistics: 1 bubble, 6 stalls, 1 drain, 2 bubbles
        do_reset();
        drive(1'b0, 1'b1, 32'h77, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (5) tick();
        chk("stats_stall5", 64'(stall_cnt), STATS ? 64'd5 : 64'd0);
        chk("stats_stall5_w2", 64'(stall_cnt2), STATS ? 64'd3 : 64'd0);
        tick();
        chk("stats_stall6", 64'(stall_cnt), STATS ? 64'd6 : 64'd0);
        chk("stats_stall6_w2_sat", 64'(stall_cnt2), STATS ? 64'd3 : 64'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) tick();
        chk("stats_bubble3", 64'(bubble_cnt), STATS ? 64'd3 : 64'd0);
        chk("stats_stall_hold", 64'(stall_cnt), STATS ? 64'd6 : 64'd0);

        // random traffic with occasional flush
        for (int n = 0; n < 10000; n++) begin
            int unsigned ov_bias;
            ov_bias = (n / 1000) % 4;
            drive(($urandom % 40) == 0, ($urandom % 4) != 0, $urandom,
                  ($urandom % 4) >= ov_bias);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
